// File: rtl/pll_rst_ctrl_pkg.sv
// Shared definitions for the PLL reset controller: state encoding and sizing helper.
package pll_rst_ctrl_pkg;

    localparam logic [2:0] ST_ASSERT_RST = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_STABLE     = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_FAIL       = 3'd4;

    typedef enum logic [2:0] {
        ASSERT_RST = ST_ASSERT_RST,
        WAIT_LOCK  = ST_WAIT_LOCK,
        STABLE     = ST_STABLE,
        RUN        = ST_RUN,
        FAIL       = ST_FAIL
    } state_e;

    // The single shared down-counter must hold the largest of the three loads.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // their inputs from before the edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, releases system reset.
// Optional macro PLL_RST_CTRL_AUTO_RELOCK_EN: loss of lock in RUN restarts instead of failing.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pll_locked,
    input  logic                               soft_reset,
    output logic                               pll_rst,
    output logic                               sys_reset_n,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic                               fail
);

    localparam int CNT_W   = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES) + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   LD_PULSE   = CNT_W'(RST_PULSE_CYCLES);
    localparam logic [CNT_W-1:0]   LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    logic                lock_s;
    state_e              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [RETRY_W-1:0]  retry_d;
    logic                lost_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        retry_d = retry_cnt;
        lost_d  = lock_lost;
        if (soft_reset) begin
            state_d = ASSERT_RST;
            cnt_d   = LD_PULSE;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            case (state)
                ASSERT_RST: begin
                    if (cnt == CNT_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = LD_TIMEOUT;
                    end else begin
                        cnt_d = cnt - CNT_LAST;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = LD_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        retry_d = retry_cnt + RETRY_W'(1);
                        if (retry_d == RETRY_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = ASSERT_RST;
                            cnt_d   = LD_PULSE;
                        end
                    end else begin
                        cnt_d = cnt - CNT_LAST;
                    end
                end
                STABLE: begin
                    // A single low sample throws away the accumulated stable time.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = LD_TIMEOUT;
                    end else if (cnt == CNT_LAST) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt - CNT_LAST;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        lost_d = 1'b1;
`ifdef PLL_RST_CTRL_AUTO_RELOCK_EN
                        state_d = ASSERT_RST;
                        cnt_d   = LD_PULSE;
                        retry_d = '0;
`else
                        state_d = FAIL;
`endif
                    end
                end
                FAIL: begin
                end
                default: begin
                    state_d = ASSERT_RST;
                    cnt_d   = LD_PULSE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change on
    // the same edge as the state and never follow an input combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ASSERT_RST;
            cnt         <= LD_PULSE;
            retry_cnt   <= '0;
            lock_lost   <= 1'b0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            retry_cnt   <= retry_d;
            lock_lost   <= lost_d;
            pll_rst     <= (state_d == ASSERT_RST) || (state_d == FAIL);
            sys_reset_n <= (state_d == RUN);
            fail        <= (state_d == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: stimulus queues timed output events, a monitor checks them.
module tb_pll_rst_ctrl;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic       fail;

    pll_rst_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .soft_reset  (soft_reset),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt),
        .fail        (fail)
    );

    typedef struct packed {
        logic       pll_rst;
        logic       sys_reset_n;
        logic       lock_lost;
        logic [1:0] retry;
        logic       fail;
    } obs_t;

    typedef struct {
        int    cyc;
        obs_t  o;
        string name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;
    obs_t cur;
    obs_t prev;
    exp_t e;
    int   b, c, d, f, g, h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic p, input logic s, input logic l,
                        input logic [1:0] r, input logic fl, input string nm);
        exp_t x;
        x.cyc  = at;
        x.o    = {p, s, l, r, fl};
        x.name = nm;
        q.push_back(x);
    endtask

    // Returns #1 after the falling edge that follows posedge number n.
    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},     32'(pll_rst),     32'd1);
        check({tag, "_sys_reset_n"}, 32'(sys_reset_n), 32'd0);
        check({tag, "_lock_lost"},   32'(lock_lost),   32'd0);
        check({tag, "_retry_cnt"},   32'(retry_cnt),   32'd0);
        check({tag, "_fail"},        32'(fail),        32'd0);
    endtask

    // Monitor: every output change must match the next queued event in time and value.
    always @(negedge clk) begin
        cur = {pll_rst, sys_reset_n, lock_lost, retry_cnt, fail};
        if (mon_en && (cur !== prev)) begin
            if (q.size() == 0) begin
                check("spurious_change", 32'(cur), 32'(prev));
            end else begin
                e = q.pop_front();
                check({e.name, "_cycle"},   32'(cyc),   32'(e.cyc));
                check({e.name, "_outputs"}, 32'(cur),   32'(e.o));
            end
        end
        prev = cur;
    end

    initial begin
        reset_n    = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values("por");

        // Power-up: lock arrives 10 cycles after release.
        repeat (3) @(negedge clk);
        #1;
        b = cyc;
        push(b + 4,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "first_pulse_end");
        push(b + 21, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "first_run");
        mon_en  = 1'b1;
        reset_n = 1'b1;
        at_cyc(b + 10);
        pll_locked = 1'b1;

        // Lose lock while running.
        c = b + 25;
        at_cyc(c);
`ifdef PLL_RST_CTRL_AUTO_RELOCK_EN
        push(c + 3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, "relock_pulse_start");
        push(c + 7, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, "relock_pulse_end");
`else
        push(c + 3, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, "lost_to_fail");
`endif
        pll_locked = 1'b0;

        // Restart with no lock at all: two timed-out attempts end in FAIL.
        d = c + 10;
        at_cyc(d);
        push(d + 1,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "soft_restart");
        push(d + 5,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "try0_wait");
        push(d + 37, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, "timeout1");
        push(d + 41, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, "try1_wait");
        push(d + 73, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, "timeout2_fail");
        soft_reset = 1'b1;
        at_cyc(d + 1);
        soft_reset = 1'b0;

        // Soft reset out of FAIL on the same cycle lock rises, then a 2-cycle glitch in STABLE.
        f = d + 80;
        at_cyc(f);
        push(f + 1,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "fail_soft_restart");
        push(f + 5,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "post_fail_wait");
        push(f + 20, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "glitch_run");
        soft_reset = 1'b1;
        pll_locked = 1'b1;
        at_cyc(f + 1);
        soft_reset = 1'b0;
        at_cyc(f + 7);
        pll_locked = 1'b0;
        at_cyc(f + 9);
        pll_locked = 1'b1;

        // Asynchronous reset in the middle of STABLE.
        g = f + 25;
        at_cyc(g);
        push(g + 1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, "pre_reset_restart");
        push(g + 5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "pre_reset_wait");
        soft_reset = 1'b1;
        at_cyc(g + 1);
        soft_reset = 1'b0;
        at_cyc(g + 9);
        check("events_before_async_reset", 32'(q.size()), 32'd0);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1 check_reset_values("async");
        repeat (2) @(negedge clk);
        #1;
        h = cyc;
        push(h + 4,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "rerelease_pulse_end");
        push(h + 13, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, "rerelease_run");
        mon_en  = 1'b1;
        reset_n = 1'b1;

        at_cyc(h + 20);
        check("pending_events", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
